// File: rtl/base_shiftl_pack.sv
// rtl/base_shiftl_pack.sv - lane packer: variable-count beats packed densely into full words.
// Optional BASE_SHIFTL_PACK_CHK_EN adds the sticky o_err protocol-error output.
module base_shiftl_pack #(
  parameter int width      = 8,
  parameter int ways       = 4,
  parameter int cnt_width  = $clog2(ways + 1),
  parameter int fill_width = $clog2(2 * ways)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_v,
  output logic                   i_r,
  input  logic [ways*width-1:0]  i_d,
  input  logic [cnt_width-1:0]   i_cnt,
  input  logic                   i_flush,
  output logic                   o_v,
  input  logic                   o_r,
  output logic [ways*width-1:0]  o_d,
  output logic [cnt_width-1:0]   o_cnt
`ifdef BASE_SHIFTL_PACK_CHK_EN
  ,
  output logic                   o_err
`endif
);

  localparam int BW = 2 * ways * width;
  localparam logic [fill_width-1:0] WAYS_F = fill_width'(ways);
  localparam logic [cnt_width-1:0]  WAYS_C = cnt_width'(ways);

  logic [BW-1:0]          lane_buf, buf_nxt;
  logic [fill_width-1:0]  fill, fill_nxt, drained;
  logic                   flush_pend, flush_nxt;
  logic [cnt_width-1:0]   ecnt;
  logic [ways*width-1:0]  masked;
  logic                   ofire, ifire;

  always_comb begin
    ecnt   = (i_cnt > WAYS_C) ? WAYS_C : i_cnt;
    masked = '0;
    for (int k = 0; k < ways; k++) begin
      if (k < int'(ecnt)) masked[k*width +: width] = i_d[k*width +: width];
    end
  end

  // Output side: a word is offered once full, or when a flush has left a partial word.
  always_comb begin
    o_v   = (fill >= WAYS_F) | (flush_pend & (fill != '0));
    o_cnt = (fill >= WAYS_F) ? WAYS_C : cnt_width'(fill);
    o_d   = lane_buf[ways*width-1:0];
  end

  assign ofire   = o_v & o_r;
  assign drained = fill - (ofire ? fill_width'(o_cnt) : '0);
  // Appends only ever land at lane >= ways while a word is pending, so o_d stays stable.
  assign i_r     = !flush_pend & (drained < WAYS_F);
  assign ifire   = i_v & i_r;

  always_comb begin
    buf_nxt = lane_buf >> ((ofire ? int'(o_cnt) : 0) * width);
    if (ifire) buf_nxt = buf_nxt | (BW'(masked) << (int'(drained) * width));
    fill_nxt  = drained + (ifire ? fill_width'(ecnt) : '0);
    flush_nxt = flush_pend;
    if (ifire & i_flush & (fill_nxt != '0)) flush_nxt = 1'b1;
    else if (ofire & (fill_nxt == '0))      flush_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_buf   <= '0;
      fill       <= '0;
      flush_pend <= 1'b0;
    end else begin
      lane_buf   <= buf_nxt;
      fill       <= fill_nxt;
      flush_pend <= flush_nxt;
    end
  end

`ifdef BASE_SHIFTL_PACK_CHK_EN
  logic beat_bad;

  always_comb begin
    beat_bad = (i_cnt > WAYS_C);
    for (int k = 0; k < ways; k++) begin
      if ((k >= int'(i_cnt)) && (i_d[k*width +: width] != '0)) beat_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                o_err <= 1'b0;
    else if (ifire & beat_bad) o_err <= 1'b1;
  end
`endif

endmodule
